pipe_controller: RTL and testbench
==================================

Name: pipe_controller

Overview:
Second-generation control path for the 5-stage pipelined MIPS core. Decodes the D-stage opcode/funct and carries the control bundle through the E/M/W pipeline registers, with per-stage stall/flush. Adds BNE, JAL, ANDI/ORI/SLTI, and a multi-cycle multiply/divide (MDU) sequencer that reports its own D-stage stall to the hazard unit. Sits beside the datapath and is driven by the hazard unit.

Parameters:
ALUCTRL_W, 4, width of ALU control code; only 4 is supported.
MDU_LATENCY, 32, cycles from MDU start to HI/LO write; legal range 2..64.
HAS_MDU, 1, 0 removes the sequencer; MDU ops then decode as no-ops.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
opD  in  6  D-stage opcode
functD  in  6  D-stage funct
equalD  in  1  register compare result from D
stallE  in  1  hold E/M/W control registers
flushE  in  1  bubble into E
flushM  in  1  bubble into M
pcsrcD, branchD, jumpD, jalD  out  1  D-stage branch/jump controls
alusrcE  out  2  0 = rt, 1 = sign-extended imm, 2 = zero-extended imm
regdstE  out  2  0 = rt, 1 = rd, 2 = r31
alucontrolE  out  ALUCTRL_W  ALU op
regwriteE, regwriteM, regwriteW  out  1  register-file write enable per stage
memwriteM  out  1  data memory write
resultsrcE, resultsrcM, resultsrcW  out  2  0 = ALU, 1 = memory, 2 = PC+8, 3 = HI/LO
hilo_selW  out  1  0 = LO, 1 = HI (for MFLO/MFHI)
mdu_startE  out  1  one-cycle start pulse to the MDU datapath
mdu_opE  out  2  0 = MULT, 1 = MULTU, 2 = DIV, 3 = DIVU
mdu_busy  out  1  sequencer active
mdu_done  out  1  one-cycle pulse; HI/LO write enable
mdu_stallD  out  1  stall request to the hazard unit

Behaviour:
- Decode is combinational in D.
  - R-type (op 0): funct ADD/ADDU/SUB/SUBU/AND/OR/NOR/SLT/SLTU set regwrite=1, regdst=1.
  - MFHI/MFLO: regwrite=1, regdst=1, resultsrc=3.
  - MULT/MULTU/DIV/DIVU: regwrite=0, MDU op.
  - LW: regwrite=1, resultsrc=1, alusrc=1. SW: memwrite=1, alusrc=1.
  - BEQ/BNE: branchD=1. ADDI/SLTI: alusrc=1. ANDI/ORI: alusrc=2.
  - J: jumpD=1. JAL: jumpD=1, jalD=1, regwrite=1, regdst=2, resultsrc=2.
  - Unknown op/funct: all controls 0.
- ALU codes: AND=0000, OR=0001, ADD=0010, NOR=0011, SUB=0110, SLT=0111, SLTU=1000.
- pcsrcD = branchD & (equalD XOR isBNE).
- E register priority: reset > flushE > stallE. Flush loads all zeros; stall holds the previous value.
- M register: reset/flushM load zeros; stallE holds M. W register is held by stallE and cleared only by reset.
- Reset: every registered output is 0; sequencer returns to IDLE, count=0.
- Sequencer FSM with states IDLE and BUSY; count is 6 bits.
  - IDLE→BUSY when an MDU op sits in the E register and stallE=0. mdu_startE is combinational from the E register, so it pulses exactly one cycle. count loads MDU_LATENCY-1.
  - In BUSY, count decrements each cycle, independent of stallE. When count==0: mdu_done=1 that cycle, then IDLE.
  - mdu_busy=1 while in BUSY.
- mdu_stallD = (BUSY & count!=0 & D holds MDU/MFHI/MFLO) OR (E holds an MDU op & D holds MDU/MFHI/MFLO). Therefore the dependent instruction enters E the cycle after mdu_done.
- flushE on the cycle an MDU op would enter E: no start.
- Reset mid-BUSY: immediate IDLE, no mdu_done.
- HAS_MDU=0: mdu_* outputs tied to 0.

Decomposition:
- Package ctrl_pkg: opcode/funct localparams, ALU code constants, resultsrc/regdst/alusrc enums, and the packed ctrl_t struct carried through the stages.
- Sub-module mdu_seq holds the FSM and counter. Decoders and stage registers stay in pipe_controller.

Test Plan:
- ADD, then SW, then BEQ with equalD=1 → alucontrolE=0010, regdstE=1; memwriteM=1 two cycles after SW decode; pcsrcD=1 for BEQ.
- BNE with equalD=1 → pcsrcD=0; with equalD=0 → pcsrcD=1.
- JAL → jumpD=1; regdstE=2 and resultsrcE=2; regwriteW=1 three cycles later.
- MULT then MFLO, MDU_LATENCY=4 → mdu_startE for 1 cycle; mdu_done exactly 4 cycles after start; mdu_stallD high until the done cycle; MFLO in E the next cycle.
- flushE asserted with LW in D → all E controls 0 next cycle. stallE asserted → E/M/W controls held constant.
- Reset asserted 2 cycles into BUSY → mdu_busy=0 next cycle, mdu_done never pulses, all registered outputs 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the pipeline control path: opcodes, functs, ALU codes,
// control-field enums and the control bundle carried down the pipeline.
package ctrl_pkg;

    // Opcodes
    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpSlti  = 6'b001010;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;

    // R-type functs
    localparam logic [5:0] FunctMfhi  = 6'b010000;
    localparam logic [5:0] FunctMflo  = 6'b010010;
    localparam logic [5:0] FunctAdd   = 6'b100000;
    localparam logic [5:0] FunctAddu  = 6'b100001;
    localparam logic [5:0] FunctSub   = 6'b100010;
    localparam logic [5:0] FunctSubu  = 6'b100011;
    localparam logic [5:0] FunctAnd   = 6'b100100;
    localparam logic [5:0] FunctOr    = 6'b100101;
    localparam logic [5:0] FunctNor   = 6'b100111;
    localparam logic [5:0] FunctSlt   = 6'b101010;
    localparam logic [5:0] FunctSltu  = 6'b101011;
    // MULT/MULTU/DIV/DIVU occupy 0110xx; the low two bits select the MDU op.
    localparam logic [3:0] FunctMduHi = 4'b0110;

    // ALU control codes
    localparam logic [3:0] AluAnd  = 4'b0000;
    localparam logic [3:0] AluOr   = 4'b0001;
    localparam logic [3:0] AluAdd  = 4'b0010;
    localparam logic [3:0] AluNor  = 4'b0011;
    localparam logic [3:0] AluSub  = 4'b0110;
    localparam logic [3:0] AluSlt  = 4'b0111;
    localparam logic [3:0] AluSltu = 4'b1000;

    typedef enum logic [1:0] {ResAlu, ResMem, ResPc8, ResHiLo} resultsrc_e;
    typedef enum logic [1:0] {DstRt, DstRd, DstRa} regdst_e;
    typedef enum logic [1:0] {SrcRt, SrcImmSext, SrcImmZext} alusrc_e;
    typedef enum logic [1:0] {MduMult, MduMultu, MduDiv, MduDivu} mdu_op_e;
    typedef enum logic {StIdle, StBusy} mdu_state_e;

    typedef struct packed {
        logic       regwrite;
        logic       memwrite;
        resultsrc_e resultsrc;
        alusrc_e    alusrc;
        regdst_e    regdst;
        logic [3:0] alucontrol;
        logic       hilo_sel;
        logic       mdu_en;
        mdu_op_e    mdu_op;
    } ctrl_t;

    localparam ctrl_t CtrlNop = '0;

endpackage

// File: rtl/mdu_seq.sv
// Multiply/divide sequencer: starts when an MDU op leaves E, counts the fixed
// latency down and pulses done on the last busy cycle.
module mdu_seq
    import ctrl_pkg::*;
#(
    parameter int unsigned MDU_LATENCY = 32
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic mdu_valid_i,
    input  logic stall_i,
    output logic start_o,
    output logic busy_o,
    output logic done_o,
    output logic count_nz_o
);

    localparam logic [5:0] LatM1 = 6'(MDU_LATENCY - 1);

    mdu_state_e state_q;
    logic [5:0] count_q;

    // Start only from idle and only when the op actually advances out of E.
    always_comb begin
        busy_o     = (state_q == StBusy);
        start_o    = mdu_valid_i & ~stall_i & ~busy_o;
        done_o     = busy_o & (count_q == 6'd0);
        count_nz_o = busy_o & (count_q != 6'd0);
    end

    // State and countdown; the count runs regardless of pipeline stalls.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            count_q <= 6'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_o) begin
                        state_q <= StBusy;
                        count_q <= LatM1;
                    end
                end
                StBusy: begin
                    if (count_q == 6'd0) begin
                        state_q <= StIdle;
                    end else begin
                        count_q <= count_q - 6'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: rtl/pipe_controller.sv
// Pipeline control path: D-stage decode plus E/M/W control registers with
// stall/flush, and the MDU sequencer with its D-stage interlock.
module pipe_controller
    import ctrl_pkg::*;
#(
    parameter int unsigned ALUCTRL_W   = 4,
    parameter int unsigned MDU_LATENCY = 32,
    parameter int unsigned HAS_MDU     = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           opD,
    input  logic [5:0]           functD,
    input  logic                 equalD,
    input  logic                 stallE,
    input  logic                 flushE,
    input  logic                 flushM,
    output logic                 pcsrcD,
    output logic                 branchD,
    output logic                 jumpD,
    output logic                 jalD,
    output logic [1:0]           alusrcE,
    output logic [1:0]           regdstE,
    output logic [ALUCTRL_W-1:0] alucontrolE,
    output logic                 regwriteE,
    output logic                 regwriteM,
    output logic                 regwriteW,
    output logic                 memwriteM,
    output logic [1:0]           resultsrcE,
    output logic [1:0]           resultsrcM,
    output logic [1:0]           resultsrcW,
    output logic                 hilo_selW,
    output logic                 mdu_startE,
    output logic [1:0]           mdu_opE,
    output logic                 mdu_busy,
    output logic                 mdu_done,
    output logic                 mdu_stallD
);

    ctrl_t      ctrl_d;
    ctrl_t      ctrl_e_q;
    logic       is_bne_d;
    logic       mdu_dep_d;
    logic       r_alu;
    logic [3:0] r_aluc;
    logic       regwrite_m_q, memwrite_m_q, hilo_sel_m_q;
    logic [1:0] resultsrc_m_q;
    logic       regwrite_w_q, hilo_sel_w_q;
    logic [1:0] resultsrc_w_q;

    // R-type ALU funct lookup.
    always_comb begin
        r_alu  = 1'b1;
        r_aluc = AluAdd;
        case (functD)
            FunctAdd, FunctAddu: r_aluc = AluAdd;
            FunctSub, FunctSubu: r_aluc = AluSub;
            FunctAnd:            r_aluc = AluAnd;
            FunctOr:             r_aluc = AluOr;
            FunctNor:            r_aluc = AluNor;
            FunctSlt:            r_aluc = AluSlt;
            FunctSltu:           r_aluc = AluSltu;
            default:             r_alu  = 1'b0;
        endcase
    end

    // Main D-stage decode; anything unrecognised leaves every control at 0.
    always_comb begin
        ctrl_d    = CtrlNop;
        branchD   = 1'b0;
        jumpD     = 1'b0;
        jalD      = 1'b0;
        is_bne_d  = 1'b0;
        mdu_dep_d = 1'b0;
        case (opD)
            OpRtype: begin
                if (r_alu) begin
                    ctrl_d.regwrite   = 1'b1;
                    ctrl_d.regdst     = DstRd;
                    ctrl_d.alucontrol = r_aluc;
                end else if (functD == FunctMfhi || functD == FunctMflo) begin
                    ctrl_d.regwrite  = 1'b1;
                    ctrl_d.regdst    = DstRd;
                    ctrl_d.resultsrc = ResHiLo;
                    ctrl_d.hilo_sel  = (functD == FunctMfhi);
                    mdu_dep_d        = 1'b1;
                end else if (HAS_MDU != 0 && functD[5:2] == FunctMduHi) begin
                    ctrl_d.mdu_en = 1'b1;
                    ctrl_d.mdu_op = mdu_op_e'(functD[1:0]);
                    mdu_dep_d     = 1'b1;
                end
            end
            OpLw: begin
                ctrl_d.regwrite   = 1'b1;
                ctrl_d.resultsrc  = ResMem;
                ctrl_d.alusrc     = SrcImmSext;
                ctrl_d.alucontrol = AluAdd;
            end
            OpSw: begin
                ctrl_d.memwrite   = 1'b1;
                ctrl_d.alusrc     = SrcImmSext;
                ctrl_d.alucontrol = AluAdd;
            end
            OpBeq: begin
                branchD           = 1'b1;
                ctrl_d.alucontrol = AluSub;
            end
            OpBne: begin
                branchD           = 1'b1;
                is_bne_d          = 1'b1;
                ctrl_d.alucontrol = AluSub;
            end
            OpAddi, OpSlti: begin
                ctrl_d.regwrite   = 1'b1;
                ctrl_d.alusrc     = SrcImmSext;
                ctrl_d.alucontrol = (opD == OpSlti) ? AluSlt : AluAdd;
            end
            OpAndi, OpOri: begin
                ctrl_d.regwrite   = 1'b1;
                ctrl_d.alusrc     = SrcImmZext;
                ctrl_d.alucontrol = (opD == OpOri) ? AluOr : AluAnd;
            end
            OpJ: jumpD = 1'b1;
            OpJal: begin
                jumpD            = 1'b1;
                jalD             = 1'b1;
                ctrl_d.regwrite  = 1'b1;
                ctrl_d.regdst    = DstRa;
                ctrl_d.resultsrc = ResPc8;
            end
            default: ;
        endcase
        pcsrcD = branchD & (equalD ^ is_bne_d);
    end

    // E register: flush beats stall.
    always_ff @(posedge clk) begin
        if (reset || flushE) begin
            ctrl_e_q <= CtrlNop;
        end else if (!stallE) begin
            ctrl_e_q <= ctrl_d;
        end
    end

    // M register: flush beats stall.
    always_ff @(posedge clk) begin
        if (reset || flushM) begin
            regwrite_m_q  <= 1'b0;
            memwrite_m_q  <= 1'b0;
            resultsrc_m_q <= 2'd0;
            hilo_sel_m_q  <= 1'b0;
        end else if (!stallE) begin
            regwrite_m_q  <= ctrl_e_q.regwrite;
            memwrite_m_q  <= ctrl_e_q.memwrite;
            resultsrc_m_q <= ctrl_e_q.resultsrc;
            hilo_sel_m_q  <= ctrl_e_q.hilo_sel;
        end
    end

    // W register: only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            regwrite_w_q  <= 1'b0;
            resultsrc_w_q <= 2'd0;
            hilo_sel_w_q  <= 1'b0;
        end else if (!stallE) begin
            regwrite_w_q  <= regwrite_m_q;
            resultsrc_w_q <= resultsrc_m_q;
            hilo_sel_w_q  <= hilo_sel_m_q;
        end
    end

    assign alusrcE     = ctrl_e_q.alusrc;
    assign regdstE     = ctrl_e_q.regdst;
    assign alucontrolE = ctrl_e_q.alucontrol;
    assign regwriteE   = ctrl_e_q.regwrite;
    assign resultsrcE  = ctrl_e_q.resultsrc;
    assign mdu_opE     = ctrl_e_q.mdu_op;
    assign regwriteM   = regwrite_m_q;
    assign memwriteM   = memwrite_m_q;
    assign resultsrcM  = resultsrc_m_q;
    assign regwriteW   = regwrite_w_q;
    assign resultsrcW  = resultsrc_w_q;
    assign hilo_selW   = hilo_sel_w_q;

    if (HAS_MDU != 0) begin : g_mdu
        logic count_nz;

        mdu_seq #(
            .MDU_LATENCY(MDU_LATENCY)
        ) u_mdu_seq (
            .clk_i      (clk),
            .reset_i    (reset),
            .mdu_valid_i(ctrl_e_q.mdu_en),
            .stall_i    (stallE),
            .start_o    (mdu_startE),
            .busy_o     (mdu_busy),
            .done_o     (mdu_done),
            .count_nz_o (count_nz)
        );

        // Hold an HI/LO consumer or another MDU op in D until the result lands.
        assign mdu_stallD = mdu_dep_d & (count_nz | ctrl_e_q.mdu_en);
    end else begin : g_no_mdu
        assign mdu_startE = 1'b0;
        assign mdu_busy   = 1'b0;
        assign mdu_done   = 1'b0;
        assign mdu_stallD = 1'b0;
    end

endmodule

// File: tb/tb_pipe_controller.sv
// Scoreboard bench for pipe_controller: a directed prologue then random
// instruction/control streams, checked against an instruction-level model.
module tb_pipe_controller;

    localparam int L = 4;
    localparam int NRand = 3000;

    logic clk = 1'b0;
    logic reset, equalD, stallE, flushE, flushM;
    logic [5:0] opD, functD;
    logic pcsrcD, branchD, jumpD, jalD;
    logic [1:0] alusrcE, regdstE, resultsrcE, resultsrcM, resultsrcW, mdu_opE;
    logic [3:0] alucontrolE;
    logic regwriteE, regwriteM, regwriteW, memwriteM, hilo_selW;
    logic mdu_startE, mdu_busy, mdu_done, mdu_stallD;

    always #5 clk = ~clk;

    pipe_controller #(
        .ALUCTRL_W  (4),
        .MDU_LATENCY(L),
        .HAS_MDU    (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .opD        (opD),
        .functD     (functD),
        .equalD     (equalD),
        .stallE     (stallE),
        .flushE     (flushE),
        .flushM     (flushM),
        .pcsrcD     (pcsrcD),
        .branchD    (branchD),
        .jumpD      (jumpD),
        .jalD       (jalD),
        .alusrcE    (alusrcE),
        .regdstE    (regdstE),
        .alucontrolE(alucontrolE),
        .regwriteE  (regwriteE),
        .regwriteM  (regwriteM),
        .regwriteW  (regwriteW),
        .memwriteM  (memwriteM),
        .resultsrcE (resultsrcE),
        .resultsrcM (resultsrcM),
        .resultsrcW (resultsrcW),
        .hilo_selW  (hilo_selW),
        .mdu_startE (mdu_startE),
        .mdu_opE    (mdu_opE),
        .mdu_busy   (mdu_busy),
        .mdu_done   (mdu_done),
        .mdu_stallD (mdu_stallD)
    );

    // Controls an instruction asks for, straight from the ISA table.
    typedef struct packed {
        logic       rw;
        logic       mw;
        logic [1:0] res;
        logic [1:0] src;
        logic [1:0] dst;
        logic [3:0] alu;
        logic       hi;
        logic       mdu;
        logic [1:0] mop;
        logic       dep;
        logic       br;
        logic       bne;
        logic       jmp;
        logic       jal;
    } dec_t;

    typedef struct {
        int         cyc;
        logic [3:0] d;
        logic [10:0] e;
        logic [7:0] mw;
        logic [5:0] m;
    } exp_t;

    typedef struct {
        logic [11:0] w;
        logic eq, st, fe, fm, rs;
    } ent_t;

    exp_t sb[$];
    ent_t dir[$];
    int total = 0;
    int bad = 0;

    function automatic dec_t decode(logic [11:0] w);
        dec_t d;
        logic [5:0] op, fn;
        op = w[11:6];
        fn = w[5:0];
        d = '0;
        case (op)
            6'h00: case (fn)
                6'h20, 6'h21: begin d.rw = 1; d.dst = 2'd1; d.alu = 4'b0010; end
                6'h22, 6'h23: begin d.rw = 1; d.dst = 2'd1; d.alu = 4'b0110; end
                6'h24: begin d.rw = 1; d.dst = 2'd1; d.alu = 4'b0000; end
                6'h25: begin d.rw = 1; d.dst = 2'd1; d.alu = 4'b0001; end
                6'h27: begin d.rw = 1; d.dst = 2'd1; d.alu = 4'b0011; end
                6'h2a: begin d.rw = 1; d.dst = 2'd1; d.alu = 4'b0111; end
                6'h2b: begin d.rw = 1; d.dst = 2'd1; d.alu = 4'b1000; end
                6'h10: begin d.rw = 1; d.dst = 2'd1; d.res = 2'd3; d.hi = 1; d.dep = 1; end
                6'h12: begin d.rw = 1; d.dst = 2'd1; d.res = 2'd3; d.dep = 1; end
                6'h18, 6'h19, 6'h1a, 6'h1b: begin d.mdu = 1; d.mop = fn[1:0]; d.dep = 1; end
                default: ;
            endcase
            6'h23: begin d.rw = 1; d.res = 2'd1; d.src = 2'd1; d.alu = 4'b0010; end
            6'h2b: begin d.mw = 1; d.src = 2'd1; d.alu = 4'b0010; end
            6'h04: begin d.br = 1; d.alu = 4'b0110; end
            6'h05: begin d.br = 1; d.bne = 1; d.alu = 4'b0110; end
            6'h08: begin d.rw = 1; d.src = 2'd1; d.alu = 4'b0010; end
            6'h0a: begin d.rw = 1; d.src = 2'd1; d.alu = 4'b0111; end
            6'h0c: begin d.rw = 1; d.src = 2'd2; d.alu = 4'b0000; end
            6'h0d: begin d.rw = 1; d.src = 2'd2; d.alu = 4'b0001; end
            6'h02: d.jmp = 1;
            6'h03: begin d.jmp = 1; d.jal = 1; d.rw = 1; d.dst = 2'd2; d.res = 2'd2; end
            default: ;
        endcase
        return d;
    endfunction

    function automatic logic [11:0] rand_word();
        logic [5:0] r;
        r = 6'($urandom);
        case ($urandom_range(0, 23))
            0: return {6'h00, 6'h20};
            1: return {6'h00, 6'h21};
            2: return {6'h00, 6'h22};
            3: return {6'h00, 6'h23};
            4: return {6'h00, 6'h24};
            5: return {6'h00, 6'h25};
            6: return {6'h00, 6'h27};
            7: return {6'h00, 6'h2a};
            8: return {6'h00, 6'h2b};
            9: return {6'h00, 6'h10};
            10: return {6'h00, 6'h12};
            11: return {6'h00, 4'b0110, r[1:0]};
            12: return {6'h23, r};
            13: return {6'h2b, r};
            14: return {6'h04, r};
            15: return {6'h05, r};
            16: return {6'h08, r};
            17: return {6'h0a, r};
            18: return {6'h0c, r};
            19: return {6'h0d, r};
            20: return {6'h02, r};
            21: return {6'h03, r};
            22: return {6'h3f, r};
            default: return {6'h00, r};
        endcase
    endfunction

    task automatic check(input string name, input int c, input logic [15:0] act,
                         input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, c, act, exp);
        end
    endtask

    task automatic add(input logic [11:0] w, input bit eq, input bit st, input bit fe,
                       input bit fm, input bit rs, input int n);
        ent_t e;
        e.w = w; e.eq = eq; e.st = st; e.fe = fe; e.fm = fm; e.rs = rs;
        for (int i = 0; i < n; i++) dir.push_back(e);
    endtask

    // Monitor: every cycle the DUT presents a full control vector.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            check("d_stage", x.cyc, 16'({pcsrcD, branchD, jumpD, jalD}), 16'(x.d));
            check("e_stage", x.cyc,
                  16'({alusrcE, regdstE, alucontrolE, regwriteE, resultsrcE}), 16'(x.e));
            check("mw_stage", x.cyc, 16'({regwriteM, memwriteM, resultsrcM, regwriteW,
                  resultsrcW, hilo_selW}), 16'(x.mw));
            check("mdu", x.cyc, 16'({mdu_startE, mdu_opE, mdu_busy, mdu_done, mdu_stallD}),
                  16'(x.m));
        end
    end

    // Stimulus plus instruction-level pipeline model.
    initial begin
        logic [11:0] ins_d, m_e, m_m, m_w, n_e, n_m, n_w;
        bit eq, st, fe, fm, rs, hold, have_start, busy, done, cnt_nz, start, stall_d;
        int cyc, start_cyc;
        dec_t dd, de, dm, dw;
        exp_t x;
        ent_t ent;

        ins_d = '0; m_e = '0; m_m = '0; m_w = '0;
        eq = 0; st = 0; fe = 0; fm = 0; rs = 1; hold = 0;
        have_start = 0; start_cyc = 0; cyc = 0;
        reset = 1; opD = '0; functD = '0; equalD = 0; stallE = 0; flushE = 0; flushM = 0;

        add(12'h000, 0, 0, 0, 0, 1, 2);
        add({6'h00, 6'h20}, 0, 0, 0, 0, 0, 1);  // ADD
        add({6'h2b, 6'h00}, 0, 0, 0, 0, 0, 1);  // SW
        add({6'h04, 6'h00}, 1, 0, 0, 0, 0, 1);  // BEQ taken
        add({6'h05, 6'h00}, 1, 0, 0, 0, 0, 1);  // BNE equal -> not taken
        add({6'h05, 6'h00}, 0, 0, 0, 0, 0, 1);  // BNE not equal -> taken
        add({6'h03, 6'h00}, 0, 0, 0, 0, 0, 1);  // JAL
        add(12'h000, 0, 0, 0, 0, 0, 3);
        add({6'h00, 6'h18}, 0, 0, 0, 0, 0, 1);  // MULT
        add({6'h00, 6'h12}, 0, 0, 0, 0, 0, 1);  // MFLO, interlocked
        add(12'h000, 0, 0, 0, 0, 0, 6);
        add({6'h23, 6'h00}, 0, 0, 1, 0, 0, 1);  // LW flushed out of E
        add(12'h000, 0, 0, 0, 0, 0, 1);
        add({6'h00, 6'h20}, 0, 0, 0, 0, 0, 1);
        add({6'h2b, 6'h00}, 0, 1, 0, 0, 0, 3);  // stall E/M/W
        add(12'h000, 0, 0, 0, 0, 0, 3);
        add({6'h00, 6'h1a}, 0, 0, 0, 0, 0, 1);  // DIV
        add(12'h000, 0, 0, 0, 0, 0, 2);
        add(12'h000, 0, 0, 0, 0, 1, 1);         // reset on the second busy cycle
        add(12'h000, 0, 0, 0, 0, 0, 6);

        for (int n = 0; n < dir.size() + NRand; n++) begin
            @(posedge clk);
            #1;
            // Advance the model across the edge just taken.
            if (rs) begin
                m_e = '0; m_m = '0; m_w = '0; have_start = 0;
            end else begin
                n_w = st ? m_w : m_m;
                n_m = fm ? 12'h000 : (st ? m_m : m_e);
                n_e = fe ? 12'h000 : (st ? m_e : ins_d);
                m_e = n_e; m_m = n_m; m_w = n_w;
            end
            cyc++;

            if (n < dir.size()) begin
                ent = dir[n];
            end else begin
                ent.w  = rand_word();
                ent.eq = 1'($urandom);
                ent.st = ($urandom_range(0, 7) == 0);
                ent.fe = ($urandom_range(0, 9) == 0);
                ent.fm = ($urandom_range(0, 9) == 0);
                ent.rs = ($urandom_range(0, 199) == 0);
            end
            if (!hold) ins_d = ent.w;
            eq = ent.eq; st = ent.st; fe = ent.fe; fm = ent.fm; rs = ent.rs;

            dd = decode(ins_d); de = decode(m_e); dm = decode(m_m); dw = decode(m_w);
            busy    = have_start && cyc > start_cyc && cyc <= start_cyc + L;
            done    = have_start && cyc == start_cyc + L;
            cnt_nz  = busy && cyc < start_cyc + L;
            start   = de.mdu && !st && !busy;
            stall_d = dd.dep && (cnt_nz || de.mdu);
            if (stall_d) fe = 1;  // hazard unit bubbles E while D is held
            if (start) begin
                have_start = 1;
                start_cyc  = cyc;
            end

            reset = rs; opD = ins_d[11:6]; functD = ins_d[5:0]; equalD = eq;
            stallE = st; flushE = fe; flushM = fm;

            x.cyc = cyc;
            x.d   = {dd.br & (eq ^ dd.bne), dd.br, dd.jmp, dd.jal};
            x.e   = {de.src, de.dst, de.alu, de.rw, de.res};
            x.mw  = {dm.rw, dm.mw, dm.res, dw.rw, dw.res, dw.hi};
            x.m   = {start, de.mop, busy, done, stall_d};
            sb.push_back(x);

            hold = (stall_d || st) && !rs;
        end

        @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
